// File: rtl/melody_seq.sv
// rtl/melody_seq.sv - timed (tone, duration) step sequencer for the buzzer tone bank; optional pause input under MELODY_SEQ_PAUSE_EN
module melody_seq #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LEN       = 16,
    parameter int DUR_W     = 8,
    parameter int GAP_TICKS = 1,
    localparam int AW       = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rb,
    input  logic             start,
    input  logic             stop,
`ifdef MELODY_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             loop,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [4:0]       wr_tone,
    input  logic [DUR_W-1:0] wr_dur,
    output logic [4:0]       tone,
    output logic             tone_en,
    output logic             busy,
    output logic [AW-1:0]    step,
    output logic             done
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int GW       = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] STEP_LAST = AW'(LEN - 1);
    localparam logic [GW-1:0] GAP_INIT  = GW'(GAP_TICKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t           state, state_n;
    logic [AW-1:0]    step_n;
    logic [4:0]       tone_n;
    logic [DUR_W-1:0] dur_cnt, dur_cnt_n;
    logic [GW-1:0]    gap_cnt, gap_cnt_n;
    logic [PW-1:0]    pre, pre_n;

    logic [4:0]       tbl_tone [LEN];
    logic [DUR_W-1:0] tbl_dur  [LEN];
    logic [4:0]       cur_tone;
    logic [DUR_W-1:0] cur_dur;

    logic run;
    logic tick;
    logic advance;
    logic at_end;

    // Step table write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_tone[wr_addr] <= wr_tone;
            tbl_dur[wr_addr]  <= wr_dur;
        end
    end

    assign cur_tone = tbl_tone[step];
    assign cur_dur  = tbl_dur[step];

    // run=0 freezes note/gap timing; without the pause option timing always runs
`ifdef MELODY_SEQ_PAUSE_EN
    assign run = !pause;
`else
    assign run = 1'b1;
`endif

    assign tick    = run && (pre == PRE_LAST);
    assign busy    = (state != S_IDLE);
    assign tone_en = (state == S_PLAY) && (tone < 5'd20) && run;

    // Next-state, datapath updates and the end-of-melody pulse
    always_comb begin
        state_n   = state;
        step_n    = step;
        tone_n    = tone;
        dur_cnt_n = dur_cnt;
        gap_cnt_n = gap_cnt;
        pre_n     = pre;
        advance   = 1'b0;
        at_end    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                    step_n  = '0;
                end
            end
            S_LOAD: begin
                if (cur_dur == '0) begin
                    at_end = 1'b1;
                end else begin
                    state_n   = S_PLAY;
                    dur_cnt_n = cur_dur;
                    tone_n    = cur_tone;
                    pre_n     = '0;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    pre_n = '0;
                    if (dur_cnt == DUR_W'(1)) begin
                        if (GAP_TICKS > 0) begin
                            state_n   = S_GAP;
                            gap_cnt_n = GAP_INIT;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        dur_cnt_n = dur_cnt - DUR_W'(1);
                    end
                end else if (run) begin
                    pre_n = pre + PW'(1);
                end
            end
            S_GAP: begin
                if (tick) begin
                    pre_n = '0;
                    if (gap_cnt == GW'(1)) begin
                        advance = 1'b1;
                    end else begin
                        gap_cnt_n = gap_cnt - GW'(1);
                    end
                end else if (run) begin
                    pre_n = pre + PW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (advance) begin
            if (step == STEP_LAST) begin
                at_end = 1'b1;
            end else begin
                step_n  = step + AW'(1);
                state_n = S_LOAD;
            end
        end

        // An empty melody (marker at step 0) never loops, otherwise it would spin in LOAD
        if (at_end) begin
            step_n = '0;
            if (loop && !(state == S_LOAD && step == '0)) begin
                state_n = S_LOAD;
            end else begin
                state_n = S_IDLE;
            end
        end

        done = at_end;

        if (stop) begin
            state_n = S_IDLE;
            step_n  = '0;
            done    = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rb) begin
        if (!rb) begin
            state   <= S_IDLE;
            step    <= '0;
            tone    <= '0;
            dur_cnt <= '0;
            gap_cnt <= '0;
            pre     <= '0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            tone    <= tone_n;
            dur_cnt <= dur_cnt_n;
            gap_cnt <= gap_cnt_n;
            pre     <= pre_n;
        end
    end

endmodule

// File: tb/tb_melody_seq.sv
// tb/tb_melody_seq.sv - scoreboard bench for melody_seq against a per-step timing model
`timescale 1ns/1ps
module tb_melody_seq;

    localparam int TD  = 10;
    localparam int LEN = 16;

    typedef struct packed {
        logic [31:0] cyc;
        logic [11:0] v;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rb;
    logic [1:0] start_v, stop_v, loop_v, wr_en_v;
`ifdef MELODY_SEQ_PAUSE_EN
    logic [1:0] pause_v;
`endif
    logic [3:0] wr_addr;
    logic [4:0] wr_tone;
    logic [7:0] wr_dur;

    logic [4:0] tone0, tone1;
    logic       tone_en0, tone_en1, busy0, busy1, done0, done1;
    logic [3:0] step0, step1;

    melody_seq #(.CLK_HZ(1000), .TICK_HZ(100), .LEN(LEN), .DUR_W(8), .GAP_TICKS(1)) dut (
        .clk(clk), .rb(rb), .start(start_v[0]), .stop(stop_v[0]),
`ifdef MELODY_SEQ_PAUSE_EN
        .pause(pause_v[0]),
`endif
        .loop(loop_v[0]), .wr_en(wr_en_v[0]), .wr_addr(wr_addr), .wr_tone(wr_tone),
        .wr_dur(wr_dur), .tone(tone0), .tone_en(tone_en0), .busy(busy0), .step(step0),
        .done(done0)
    );

    melody_seq #(.CLK_HZ(1000), .TICK_HZ(100), .LEN(LEN), .DUR_W(8), .GAP_TICKS(0)) dut_legato (
        .clk(clk), .rb(rb), .start(start_v[1]), .stop(stop_v[1]),
`ifdef MELODY_SEQ_PAUSE_EN
        .pause(pause_v[1]),
`endif
        .loop(loop_v[1]), .wr_en(wr_en_v[1]), .wr_addr(wr_addr), .wr_tone(wr_tone),
        .wr_dur(wr_dur), .tone(tone1), .tone_en(tone_en1), .busy(busy1), .step(step1),
        .done(done1)
    );

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    ev_t         q0[$];
    ev_t         q1[$];
    logic [11:0] tr[$];
    int          pass_len;
    int          mt_tone [2][LEN];
    int          mt_dur  [2][LEN];
    int          ptone   [2];
    logic [11:0] lv      [2];
    logic [11:0] last_obs[2];

    always @(posedge clk) cyc++;

    function automatic logic [11:0] mkv(input bit dn, input bit bz, input int st, input bit en, input int tn);
        logic [31:0] s;
        logic [31:0] t;
        s = st;
        t = tn;
        return {dn, bz, s[3:0], en, t[4:0]};
    endfunction

    function automatic logic [11:0] obs(input int d);
        if (d == 0) return {done0, busy0, step0, tone_en0, tone0};
        return {done1, busy1, step1, tone_en1, tone1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", nm, got, exp);
        end
    endtask

    task automatic check_ev(input int d, input int c, input logic [11:0] o);
        ev_t e;
        bit  have;
        have = 1'b0;
        e    = '0;
        if (d == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            have = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            have = 1'b1;
        end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL unexpected_change dut%0d cyc=%0d got=%h required=no change", d, c, o);
        end else if (int'(e.cyc) != c || e.v !== o) begin
            errors++;
            $display("FAIL event dut%0d got cyc=%0d v=%h required cyc=%0d v=%h", d, c, o, e.cyc, e.v);
        end
    endtask

    // Monitor: every visible output change must match the next expected change
    always @(negedge clk) begin
        logic [11:0] o;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                o = obs(d);
                if (o !== last_obs[d]) begin
                    check_ev(d, cyc, o);
                    last_obs[d] = o;
                end
            end
        end
    end

    // Expected per-cycle trace from the LOAD of step 0 onward, ending with one IDLE cycle
    task automatic build(input int d, input int passes, input int gap);
        int          pt, s, nd;
        bit          fin;
        logic [11:0] v;
        tr.delete();
        pt = ptone[d];
        pass_len = 0;
        for (int p = 0; p < passes; p++) begin
            s = 0;
            fin = 1'b0;
            while (!fin) begin
                if (mt_dur[d][s] == 0) begin
                    tr.push_back(mkv(1'b1, 1'b1, s, 1'b0, pt));
                    fin = 1'b1;
                end else begin
                    tr.push_back(mkv(1'b0, 1'b1, s, 1'b0, pt));
                    pt = mt_tone[d][s];
                    nd = mt_dur[d][s] * TD;
                    for (int i = 0; i < nd + gap * TD; i++)
                        tr.push_back(mkv(1'b0, 1'b1, s, (i < nd) && (pt < 20), pt));
                    if (s == LEN - 1) begin
                        v = tr.pop_back();
                        v[11] = 1'b1;
                        tr.push_back(v);
                        fin = 1'b1;
                    end else begin
                        s++;
                    end
                end
            end
            if (p == 0) pass_len = tr.size();
        end
        tr.push_back(mkv(1'b0, 1'b0, 0, 1'b0, pt));
    endtask

    task automatic emit(input int d, input int t0);
        ev_t e;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i] !== lv[d]) begin
                e.cyc = t0 + i;
                e.v   = tr[i];
                if (d == 0) q0.push_back(e);
                else q1.push_back(e);
                lv[d] = tr[i];
            end
        end
        ptone[d] = int'(lv[d][4:0]);
    endtask

    task automatic wr(input int d, input int a, input int t, input int du);
        @(posedge clk); #1;
        wr_en_v[d] = 1'b1;
        wr_addr = a[3:0];
        wr_tone = t[4:0];
        wr_dur  = du[7:0];
        @(posedge clk); #1;
        wr_en_v[d] = 1'b0;
        mt_tone[d][a] = t;
        mt_dur[d][a]  = du;
    endtask

    // stop_at: -1 none, -2 random, else trace index of the cycle stop is high
    task automatic launch(input int d, input int passes, input int stop_at, input int pause_at, input int poke);
        int          t0, tend;
        logic [11:0] v;
        @(posedge clk); #1;
        t0 = cyc + 1;
        build(d, passes, (d == 0) ? 1 : 0);
        if (pause_at >= 0) begin
            v = tr[pause_at];
            v[5] = 1'b0;
            for (int k = 0; k < 7; k++) tr.insert(pause_at, v);
        end
        if (stop_at == -2) stop_at = $urandom_range(1, tr.size() - 2);
        if (stop_at >= 0) begin
            while (tr.size() > stop_at + 1) void'(tr.pop_back());
            v = tr.pop_back();
            v[11] = 1'b0;
            tr.push_back(v);
            tr.push_back(mkv(1'b0, 1'b0, 0, 1'b0, int'(v[4:0])));
        end
        emit(d, t0);
        tend = t0 + tr.size();
        loop_v[d]  = (passes > 1);
        start_v[d] = 1'b1;
        while (cyc < tend + 3) begin
            @(posedge clk); #1;
            start_v[d] = (poke >= 0 && cyc == t0 + poke);
            stop_v[d]  = (stop_at >= 0 && cyc == t0 + stop_at);
`ifdef MELODY_SEQ_PAUSE_EN
            pause_v[d] = (pause_at >= 0 && cyc >= t0 + pause_at && cyc < t0 + pause_at + 7);
`endif
            if (passes > 1 && cyc == t0 + (passes - 1) * pass_len + 5) loop_v[d] = 1'b0;
        end
        chk($sformatf("queue_empty_dut%0d", d), (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ptone[d]    = 0;
            lv[d]       = '0;
            last_obs[d] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    initial begin
        int d, n, ps, st;
        rb = 1'b0;
        start_v = '0; stop_v = '0; loop_v = '0; wr_en_v = '0;
`ifdef MELODY_SEQ_PAUSE_EN
        pause_v = '0;
`endif
        wr_addr = '0; wr_tone = '0; wr_dur = '0;
        for (int i = 0; i < LEN; i++) begin
            mt_tone[0][i] = 0; mt_dur[0][i] = 0;
            mt_tone[1][i] = 0; mt_dur[1][i] = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_outputs_dut0", obs(0), 0);
        chk("reset_outputs_dut1", obs(1), 0);
        rb = 1'b1;
        mon_en = 1'b1;

        wr(0, 0, 3, 2); wr(0, 1, 31, 1); wr(0, 2, 0, 0);
        launch(0, 1, -1, -1, 15);
        launch(0, 3, -1, -1, -1);

        for (int i = 0; i < LEN; i++) wr(1, i, i, 1);
        launch(1, 1, -1, -1, 5);

        launch(0, 1, 10, -1, -1);
        launch(0, 1, 52, -1, -1);

        @(posedge clk); #1;
        start_v[0] = 1'b1; stop_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0; stop_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("start_stop_idle_busy", busy0, 0);
        chk("start_stop_idle_step", step0, 0);

`ifdef MELODY_SEQ_PAUSE_EN
        wr(0, 0, 5, 2); wr(0, 1, 0, 0);
        launch(0, 1, -1, 6, -1);
`endif

        mon_en = 1'b0;
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (8) @(posedge clk);
        #2 rb = 1'b0;
        #1;
        chk("async_reset_dut0", obs(0), 0);
        chk("async_reset_dut1", obs(1), 0);
        #2 rb = 1'b1;
        model_reset();
        mon_en = 1'b1;
        launch(0, 1, -1, -1, -1);

        for (int it = 0; it < 8; it++) begin
            d = $urandom_range(0, 1);
            n = $urandom_range(1, 5);
            for (int a = 0; a < n; a++) wr(d, a, $urandom_range(0, 31), $urandom_range(1, 3));
            wr(d, n, $urandom_range(0, 31), 0);
            ps = $urandom_range(1, 2);
            st = -1;
            if ($urandom_range(0, 2) == 0) begin
                ps = 1;
                st = -2;
            end
            launch(d, ps, st, -1, (st == -1) ? 5 : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/melody_seq.md
Name: melody_seq

Overview:
- Step sequencer for the buzzer tone bank: plays a programmable table of (tone, duration) steps by driving the tone-select index into the 20-way divider mux, plus a gate.
- Sits between the user controls (start/stop/loop) and the divider bank (tone code 0..19 = 1..20 kHz).
- Replaces manual up/down tone stepping with timed melody playback.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- TICK_HZ, 100, duration unit rate; TICK_DIV = CLK_HZ/TICK_HZ, integer, ≥2.
- LEN, 16, table depth in steps (power of two); AW = $clog2(LEN).
- DUR_W, 8, duration field width in ticks.
- GAP_TICKS, 1, silent ticks inserted after every note; 0 = legato, no gap.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rb  in  1  asynchronous active-low reset.
- start  in  1  level sampled per cycle; begin playback from step 0.
- stop  in  1  abort playback.
- loop  in  1  restart from step 0 at end of melody, sampled at end of melody.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_tone  in  5  tone code: 0..19 = divider index; 20..31 = rest.
- wr_dur  in  DUR_W  duration in ticks; 0 = end-of-melody marker.
- tone  out  5  divider select to the tone bank.
- tone_en  out  1  audible gate; output is silenced when 0.
- busy  out  1  high in any state other than IDLE.
- step  out  AW  index of the current step.
- done  out  1  one-cycle pulse at each natural end of melody.

Behaviour:
- Reset (rb=0, async): state IDLE, tone=0, tone_en=0, busy=0, step=0, done=0, prescaler=0. Table contents are not reset. Software must program the table before use.
- Table: LEN x (5+DUR_W) registers. A write takes effect the next cycle. Writes are legal in any state. A write to the step currently playing takes effect only on the next LOAD of that step.
- Prescaler: cleared on every entry to PLAY and to GAP. tick=1 when prescaler==TICK_DIV-1, then the prescaler wraps to 0.
- IDLE:
  - start=1 and stop=0 → LOAD next cycle, step=0, busy=1.
  - Otherwise hold, with tone_en=0.
- LOAD (exactly 1 cycle): read entry[step].
  - dur==0 → END.
  - Otherwise → PLAY with dur_cnt=dur, tone=entry tone, tone_en=(tone<20).
- PLAY:
  - On tick, dur_cnt decrements.
  - When tick occurs with dur_cnt==1:
    - GAP_TICKS>0 → GAP, tone_en=0, gap_cnt=GAP_TICKS.
    - GAP_TICKS==0 → ADVANCE.
  - PLAY lasts exactly dur*TICK_DIV cycles. tone holds its value throughout.
- GAP:
  - On tick, gap_cnt decrements.
  - Tick at gap_cnt==1 → ADVANCE.
  - Lasts GAP_TICKS*TICK_DIV cycles. tone_en=0.
- ADVANCE (combinational decision, no extra cycle):
  - step==LEN-1 → END.
  - Otherwise step+1 and go to LOAD next cycle.
- END (no extra cycle):
  - done=1 for one cycle.
  - loop=1 → step=0, LOAD.
  - Otherwise IDLE, busy=0.
  - An entry with dur==0 at step 0 while loop=1 → IDLE, to avoid a spin.
- stop=1 in any state → IDLE next cycle: tone_en=0, busy=0, step=0, no done pulse.
  - stop beats start in the same cycle.
  - stop beats a tick that lands in the same cycle.
- start while busy: ignored, no restart.
- tone retains its last value in IDLE. The downstream mux must qualify on tone_en.
- Width: dur_cnt is DUR_W bits. gap_cnt is wide enough for GAP_TICKS. step wraps only through END.

Optional Feature:
- Macro: MELODY_SEQ_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit, placed after stop).
  - While pause=1 in PLAY or GAP: prescaler, dur_cnt and gap_cnt freeze, tone_en is forced 0, busy stays 1.
  - On release, timing resumes where it stopped and tone_en is restored to (tone<20) if in PLAY.
  - pause is ignored in IDLE and LOAD.
  - stop overrides pause.
- Undefined: no pause port. Timing is never frozen.

Test Plan (CLK_HZ=1000, TICK_HZ=100 → TICK_DIV=10, GAP_TICKS=1, LEN=16):
- Reset mid-PLAY → all outputs 0 immediately (async). After release, state is IDLE and the table is unchanged.
- Table {0:(3,2), 1:(31,1), 2:(0,0)}, start pulse at cycle N:
  - busy=1 at N+1.
  - tone=3, tone_en=1 from N+2 for 20 cycles.
  - Then 10 cycles with tone_en=0 (gap).
  - Then LOAD.
  - Step 1 (rest): tone=31, tone_en=0 for 10 cycles, then gap.
  - Step 2 LOAD: done=1 for one cycle, busy=0 the cycle after.
- Same table with loop=1 → done pulses every 53 cycles and step returns to 0. Deassert loop → next END goes to IDLE.
- All 16 entries dur=1, tone=i, GAP_TICKS=0 → tone steps 0..15 every 11 cycles. done after step 15 with no marker needed.
- stop asserted in the same cycle as a PLAY tick, and separately start+stop together in IDLE → IDLE next cycle, done=0, step=0. start while busy → no effect on step or timing.
- MELODY_SEQ_PAUSE_EN: pause high for 7 cycles mid-note of dur=2 → tone_en=0 during pause. Note total length becomes 27 cycles.
